// File: rtl/camera_capture_ctrl.sv
// Frame-capture sequencer: arms on start, optionally decimates frames, gates whole
// frames from the camera stream to the output, checks frame size and watches for stalls.
module camera_capture_ctrl #(
    parameter int COLS   = 16,
    parameter int ROWS   = 12,
    parameter int SKIP_W = 4,
    parameter int TO_W   = 24
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              continuous,
    input  logic [SKIP_W-1:0]                 skip,
    input  logic [TO_W-1:0]                   timeout,
    input  logic                              err_clr,
    input  logic                              i_sof,
    input  logic                              i_eof,
    input  logic                              i_vld,
    input  logic [7:0]                        i_dat,
    output logic                              o_sof,
    output logic                              o_eof,
    output logic                              o_vld,
    output logic [7:0]                        o_dat,
    output logic                              busy,
    output logic                              done,
    output logic                              err_size,
    output logic                              err_timeout,
    output logic [15:0]                       frame_cnt,
    output logic [$clog2(ROWS*COLS+1)-1:0]    pix_cnt
);

    localparam int FRAME_PIX = ROWS * COLS;
    localparam int PIX_W     = $clog2(FRAME_PIX + 1);
    localparam logic [PIX_W-1:0] PIX_MAX   = '1;
    localparam logic [PIX_W-1:0] PIX_FRAME = PIX_W'(FRAME_PIX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        DROP    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [TO_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                stop_pend_q, stop_pend_d;
    logic                err_size_q, err_size_d;
    logic                err_timeout_q, err_timeout_d;
    logic                done_pend_q, done_q;
    logic                o_vld_q, o_sof_q, o_eof_q;
    logic [7:0]          o_dat_q;

    logic                fwd;
    logic                frame_end;
    logic                good;
    logic                wd_expire;
    logic                err_size_set;
    logic                err_timeout_set;
    logic [PIX_W-1:0]    cap_cnt;

    function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
        return (v == PIX_MAX) ? v : v + PIX_W'(1);
    endfunction

    assign wd_expire = (timeout != '0) && (wd_cnt_q == timeout - TO_W'(1));

    always_comb begin
        state_d         = state_q;
        skip_cnt_d      = skip_cnt_q;
        pix_cnt_d       = pix_cnt_q;
        frame_cnt_d     = frame_cnt_q;
        stop_pend_d     = stop_pend_q;
        err_size_set    = 1'b0;
        err_timeout_set = 1'b0;
        fwd             = 1'b0;
        frame_end       = 1'b0;
        good            = 1'b0;
        cap_cnt         = pix_cnt_q;

        if (state_q != IDLE && wd_expire) begin
            // Stalled sensor: abandon whatever is in flight without an o_eof.
            state_d         = IDLE;
            err_timeout_set = 1'b1;
            stop_pend_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    stop_pend_d = 1'b0;
                    if (start && !stop) begin
                        state_d    = ARM;
                        skip_cnt_d = skip;
                    end
                end
                ARM: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (i_vld && i_sof) begin
                        if (skip_cnt_q == '0) begin
                            state_d = CAPTURE;
                            fwd     = 1'b1;
                            cap_cnt = PIX_W'(1);
                        end else begin
                            skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                            // A one-pixel frame is already over, so stay armed.
                            if (!i_eof) state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (i_vld && i_eof) begin
                        state_d = ARM;
                    end
                end
                CAPTURE: begin
                    if (stop) stop_pend_d = 1'b1;
                    if (i_vld) begin
                        fwd = 1'b1;
                        if (i_sof) begin
                            err_size_set = 1'b1;
                            cap_cnt      = PIX_W'(1);
                        end else begin
                            cap_cnt = sat_inc(pix_cnt_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (fwd) begin
                pix_cnt_d = cap_cnt;
                frame_end = i_eof;
            end

            if (frame_end) begin
                if (cap_cnt == PIX_FRAME) begin
                    good        = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    err_size_set = 1'b1;
                end
                if (continuous && !(stop_pend_q || stop)) begin
                    state_d    = ARM;
                    skip_cnt_d = skip;
                end else begin
                    state_d = IDLE;
                end
            end
        end

        if (state_d != state_q || i_vld) begin
            wd_cnt_d = '0;
        end else if (state_q != IDLE) begin
            wd_cnt_d = wd_cnt_q + TO_W'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end

        // A new error event beats a simultaneous clear.
        err_size_d    = (err_size_q & ~err_clr) | err_size_set;
        err_timeout_d = (err_timeout_q & ~err_clr) | err_timeout_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            skip_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            wd_cnt_q      <= '0;
            stop_pend_q   <= 1'b0;
            err_size_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            done_pend_q   <= 1'b0;
            done_q        <= 1'b0;
            o_vld_q       <= 1'b0;
            o_sof_q       <= 1'b0;
            o_eof_q       <= 1'b0;
            o_dat_q       <= '0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            stop_pend_q   <= stop_pend_d;
            err_size_q    <= err_size_d;
            err_timeout_q <= err_timeout_d;
            // done trails o_eof by one cycle.
            done_pend_q   <= good;
            done_q        <= done_pend_q;
            o_vld_q       <= fwd;
            o_sof_q       <= fwd & i_sof;
            o_eof_q       <= fwd & i_eof;
            if (fwd) o_dat_q <= i_dat;
        end
    end

    assign o_vld       = o_vld_q;
    assign o_sof       = o_sof_q;
    assign o_eof       = o_eof_q;
    assign o_dat       = o_dat_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err_size    = err_size_q;
    assign err_timeout = err_timeout_q;
    assign frame_cnt   = frame_cnt_q;
    assign pix_cnt     = pix_cnt_q;

endmodule
